// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access stage: size and write-back codes,
// FSM state encoding and lane helper functions.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_LOAD = 2'b01;
    localparam logic [1:0] M2R_PC   = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    // Select the addressed lane of a read word and extend it to 32 bits.
    function automatic logic [31:0] lane_extract(input logic [31:0] rdata,
                                                 input logic [1:0]  off,
                                                 input logic [1:0]  size,
                                                 input logic        sgn);
        logic [31:0] sh;
        logic [31:0] res;
        sh = rdata >> {off, 3'b000};
        case (size)
            SZ_BYTE: res = {{24{sgn & sh[7]}}, sh[7:0]};
            SZ_HALF: res = {{16{sgn & sh[15]}}, sh[15:0]};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Half accesses need bit 0 clear, word accesses (and the unused code) need both low bits clear.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic res;
        case (size)
            SZ_BYTE: res = 1'b0;
            SZ_HALF: res = off[0];
            default: res = (off != 2'b00);
        endcase
        return res;
    endfunction

    // Write-back source mux; code 11 falls back to the ALU result.
    function automatic logic [31:0] wb_select(input logic [1:0]  sel,
                                              input logic [31:0] alu,
                                              input logic [31:0] load,
                                              input logic [31:0] pc);
        logic [31:0] res;
        case (sel)
            M2R_LOAD: res = load;
            M2R_PC:   res = pc;
            default:  res = alu;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Byte-lane steering: byte enables, store-data replication and load extraction.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic        sgn,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_data
);

    // Byte enables and replicated store data for the requested access size.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                be        = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be        = 4'b0011 << off;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    assign load_data = lane_extract(rdata, off, size, sgn);

endmodule

// File: rtl/mem_access_unit.sv
// Memory access stage: issues one bus cycle per load/store, waits for ack or
// timeout, and registers the write-back result and status pulses.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_rd,
    input  logic              in_wr,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [31:0]       in_alu,
    input  logic [31:0]       in_newpc,
    input  logic [1:0]        in_memtoreg,
    input  logic [4:0]        in_dst,
    output logic              stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    output logic              wb_valid,
    output logic [4:0]        wb_dst,
    output logic [31:0]       wb_data,
    output logic              misalign_exc,
    output logic              timeout_exc,
    output logic              read_acc,
    output logic              write_acc
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              sgn_q, sgn_d;
    logic [4:0]        dst_q, dst_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_dst_q, wb_dst_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              mis_q, mis_d;
    logic              tmo_q, tmo_d;
    logic              racc_q, racc_d;
    logic              wacc_q, wacc_d;
    logic              stall_s;

    logic              in_wait_s;
    logic [1:0]        la_size_s;
    logic [1:0]        la_off_s;
    logic              la_sgn_s;
    logic [3:0]        la_be_s;
    logic [31:0]       la_wdata_s;
    logic [31:0]       la_load_s;

    // While waiting, steer with the latched request; otherwise with the live inputs.
    assign in_wait_s = (state_q == ST_WAIT);
    assign la_size_s = in_wait_s ? size_q : in_size;
    assign la_off_s  = in_wait_s ? off_q  : in_addr[1:0];
    assign la_sgn_s  = in_wait_s ? sgn_q  : in_signed;

    mem_lane_align u_lane (
        .size      (la_size_s),
        .off       (la_off_s),
        .sgn       (la_sgn_s),
        .wdata     (in_wdata),
        .rdata     (bus_rdata),
        .be        (la_be_s),
        .wdata_rep (la_wdata_s),
        .load_data (la_load_s)
    );

    // Next-state, request latching, write-back and pulse generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        off_d      = off_q;
        sgn_d      = sgn_q;
        dst_d      = dst_q;
        wb_valid_d = 1'b0;
        wb_dst_d   = wb_dst_q;
        wb_data_d  = wb_data_q;
        mis_d      = 1'b0;
        tmo_d      = 1'b0;
        racc_d     = 1'b0;
        wacc_d     = 1'b0;
        stall_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (in_rd || in_wr) begin
                        if (is_misaligned(in_size, in_addr[1:0])) begin
                            mis_d = 1'b1;
                        end else begin
                            stall_s = 1'b1;
                            state_d = ST_WAIT;
                            cnt_d   = 8'd0;
                            we_d    = in_wr;
                            addr_d  = {in_addr[ADDR_W-1:2], 2'b00};
                            be_d    = la_be_s;
                            wdata_d = la_wdata_s;
                            size_d  = in_size;
                            off_d   = in_addr[1:0];
                            sgn_d   = in_signed;
                            dst_d   = in_dst;
                        end
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_dst_d   = in_dst;
                        wb_data_d  = wb_select(in_memtoreg, in_alu, la_load_s, in_newpc);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus_ack) begin
                    state_d = ST_IDLE;
                    if (we_q) begin
                        wacc_d = 1'b1;
                    end else begin
                        racc_d     = 1'b1;
                        wb_valid_d = 1'b1;
                        wb_dst_d   = dst_q;
                        wb_data_d  = la_load_s;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = ST_IDLE;
                    cnt_d   = cnt_q + 8'd1;
                end else begin
                    stall_s = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched request and registered outputs; reset clears everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0000_0000;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            sgn_q      <= 1'b0;
            dst_q      <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_dst_q   <= 5'd0;
            wb_data_q  <= 32'h0000_0000;
            mis_q      <= 1'b0;
            tmo_q      <= 1'b0;
            racc_q     <= 1'b0;
            wacc_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            size_q     <= size_d;
            off_q      <= off_d;
            sgn_q      <= sgn_d;
            dst_q      <= dst_d;
            wb_valid_q <= wb_valid_d;
            wb_dst_q   <= wb_dst_d;
            wb_data_q  <= wb_data_d;
            mis_q      <= mis_d;
            tmo_q      <= tmo_d;
            racc_q     <= racc_d;
            wacc_q     <= wacc_d;
        end
    end

    // Stall is combinational so upstream holds in the same cycle; reset forces it low.
    assign stall        = stall_s & reset;
    assign bus_req      = in_wait_s;
    assign bus_we       = we_q;
    assign bus_addr     = addr_q;
    assign bus_be       = be_q;
    assign bus_wdata    = wdata_q;
    assign wb_valid     = wb_valid_q;
    assign wb_dst       = wb_dst_q;
    assign wb_data      = wb_data_q;
    assign misalign_exc = mis_q;
    assign timeout_exc  = tmo_q;
    assign read_acc     = racc_q;
    assign write_acc    = wacc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized
// instructions checked against a behavioural model of the access rules.
module tb_mem_access_unit;

    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_rd, in_wr, in_signed;
    logic [1:0]    in_size, in_memtoreg;
    logic [AW-1:0] in_addr;
    logic [31:0]   in_wdata, in_alu, in_newpc;
    logic [4:0]    in_dst;
    logic          stall, bus_req, bus_we, bus_ack;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_be;
    logic [31:0]   bus_wdata, bus_rdata;
    logic          wb_valid;
    logic [4:0]    wb_dst;
    logic [31:0]   wb_data;
    logic          misalign_exc, timeout_exc, read_acc, write_acc;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_rd(in_rd), .in_wr(in_wr),
        .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_alu(in_alu), .in_newpc(in_newpc),
        .in_memtoreg(in_memtoreg), .in_dst(in_dst),
        .stall(stall), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack),
        .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
        .misalign_exc(misalign_exc), .timeout_exc(timeout_exc),
        .read_acc(read_acc), .write_acc(write_acc)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
        int v;
        if (sz == 2'd0)      v = 1 << off;
        else if (sz == 2'd1) v = 3 << off;
        else                 v = 15;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (sz == 2'd1) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sgn);
        longint v;
        longint nb;
        nb = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        v  = (longint'(rd) >> (8 * off)) & ((64'sd1 <<< nb) - 64'sd1);
        if (sgn && nb < 32 && v >= (64'sd1 <<< (nb - 1))) v = v - (64'sd1 <<< nb);
        return v[31:0];
    endfunction

    function automatic bit m_aligned(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd1) return a[0] == 1'b0;
        if (sz == 2'd2) return a[1:0] == 2'b00;
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_wb(input logic [1:0] sel, input logic [31:0] alu,
                                         input logic [31:0] ld, input logic [31:0] pc);
        if (sel == 2'd1) return ld;
        if (sel == 2'd2) return pc;
        return alu;
    endfunction

    // One instruction from presentation to retirement; entered and left at posedge+1.
    // kind: 0 ALU, 1 load, 2 store. ack_at: WAIT cycle index carrying bus_ack.
    task automatic run_op(input int kind, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] alu, input logic [31:0] pc,
                          input logic [1:0] m2r, input logic [4:0] dst,
                          input int ack_at, input logic [31:0] rdata, input logic idle_ack);
        bit ack;
        bit last;
        in_valid = 1'b1; in_rd = (kind == 1); in_wr = (kind == 2);
        in_size = sz; in_signed = sgn; in_addr = addr; in_wdata = wd;
        in_alu = alu; in_newpc = pc; in_memtoreg = m2r; in_dst = dst;
        bus_ack = idle_ack; bus_rdata = rdata;
        #1;
        if (kind == 0) begin
            chk("alu_stall", {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
            chk("alu_wbv", {31'd0, wb_valid}, 32'd1);
            chk("alu_dst", {27'd0, wb_dst}, {27'd0, dst});
            chk("alu_data", wb_data, m_wb(m2r, alu, m_load(rdata, addr[1:0], sz, sgn), pc));
            chk("alu_acc", {30'd0, read_acc, write_acc}, 32'd0);
        end else if (!m_aligned(sz, addr)) begin
            chk("mis_stall", {31'd0, stall}, 32'd0);
            chk("mis_req0", {31'd0, bus_req}, 32'd0);
            @(posedge clk); #1;
            chk("mis_exc", {31'd0, misalign_exc}, 32'd1);
            chk("mis_wbv", {31'd0, wb_valid}, 32'd0);
            chk("mis_req1", {31'd0, bus_req}, 32'd0);
        end else begin
            chk("ent_stall", {31'd0, stall}, 32'd1);
            @(posedge clk); #1;
            for (int w = 0; w < TO + 4; w++) begin
                ack  = (w == ack_at);
                last = (w == TO - 1);
                bus_ack = ack; bus_rdata = rdata;
                #1;
                chk("w_req", {31'd0, bus_req}, 32'd1);
                chk("w_we", {31'd0, bus_we}, {31'd0, kind == 2});
                chk("w_addr", bus_addr, {addr[31:2], 2'b00});
                chk("w_be", {28'd0, bus_be}, {28'd0, m_be(sz, addr[1:0])});
                if (kind == 2) chk("w_wdata", bus_wdata, m_wdata(sz, wd));
                chk("w_stall", {31'd0, stall}, {31'd0, !(ack || last)});
                @(posedge clk); #1;
                if (ack || last) begin
                    chk("end_racc", {31'd0, read_acc}, {31'd0, ack && kind == 1});
                    chk("end_wacc", {31'd0, write_acc}, {31'd0, ack && kind == 2});
                    chk("end_tmo", {31'd0, timeout_exc}, {31'd0, !ack});
                    chk("end_wbv", {31'd0, wb_valid}, {31'd0, ack && kind == 1});
                    if (ack && kind == 1) begin
                        chk("ld_data", wb_data, m_load(rdata, addr[1:0], sz, sgn));
                        chk("ld_dst", {27'd0, wb_dst}, {27'd0, dst});
                    end
                    chk("end_req", {31'd0, bus_req}, 32'd0);
                    break;
                end
                chk("w_tmo0", {31'd0, timeout_exc}, 32'd0);
            end
        end
        in_valid = 1'b0; in_rd = 1'b0; in_wr = 1'b0; bus_ack = 1'b0;
    endtask

    // A cycle with nothing presented: every pulse must be low.
    task automatic bubble(input logic ack);
        bus_ack = ack;
        @(posedge clk); #1;
        chk("bub_pulses", {26'd0, wb_valid, misalign_exc, timeout_exc, read_acc, write_acc, bus_req},
            32'd0);
        bus_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_rd = 1'b0; in_wr = 1'b0; in_signed = 1'b0;
        in_size = 2'd0; in_memtoreg = 2'd0; in_addr = '0; in_wdata = '0;
        in_alu = '0; in_newpc = '0; in_dst = '0; bus_ack = 1'b0; bus_rdata = '0;
        #12;
        chk("rst_ctl", {24'd0, stall, bus_req, bus_we, wb_valid, misalign_exc, timeout_exc,
                        read_acc, write_acc}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_wdata", bus_wdata, 32'd0);
        chk("rst_wb", wb_data, 32'd0);
        chk("rst_dst", {27'd0, wb_dst}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // ALU write-back, then pulse must drop; ack while idle is ignored.
        run_op(0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h1234_5678, 32'h0, 2'b00, 5'd3, 0, 32'h0, 1'b0);
        bubble(1'b1);
        // Signed byte load at lane 3, two unacked wait cycles.
        run_op(1, 2'd0, 1'b1, 32'h0000_1003, 32'h0, 32'h0, 32'h0, 2'b01, 5'd5, 2, 32'h80FF_FFFF, 1'b0);
        // Halfword store at lane 2.
        run_op(2, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 32'h0, 2'b00, 5'd0, 0,
               32'h0, 1'b0);
        bubble(1'b0);
        // Misaligned word load.
        run_op(1, 2'd2, 1'b0, 32'h0000_3002, 32'h0, 32'h0, 32'h0, 2'b01, 5'd7, 0, 32'h0, 1'b0);
        // Word load with no ack: timeout.
        run_op(1, 2'd2, 1'b0, 32'h0000_4000, 32'h0, 32'h0, 32'h0, 2'b01, 5'd8, 1000, 32'h0, 1'b0);
        bubble(1'b0);
        // Ack on the last permitted wait cycle completes normally.
        run_op(1, 2'd2, 1'b0, 32'h0000_5004, 32'h0, 32'h0, 32'h0, 2'b01, 5'd9, TO - 1,
               32'hCAFE_F00D, 1'b0);
        // Write-back from PC and the 11 code behaving as ALU.
        run_op(0, 2'd0, 1'b0, 32'h0, 32'h0, 32'hAAAA_0001, 32'h0000_0400, 2'b10, 5'd1, 0, 32'h0, 1'b0);
        run_op(0, 2'd0, 1'b0, 32'h0, 32'h0, 32'hAAAA_0002, 32'h0000_0404, 2'b11, 5'd2, 0, 32'h0, 1'b0);

        // Reset in the middle of a bus cycle.
        in_valid = 1'b1; in_rd = 1'b1; in_size = 2'd2; in_addr = 32'h0000_6000; in_dst = 5'd4;
        @(posedge clk); #1;
        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        chk("mrst_req", {31'd0, bus_req}, 32'd0);
        chk("mrst_stall", {31'd0, stall}, 32'd0);
        in_valid = 1'b0; in_rd = 1'b0;
        #1;
        reset = 1'b1;
        bubble(1'b1);
        bubble(1'b0);
        run_op(0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h0BAD_F00D, 32'h0, 2'b00, 5'd6, 0, 32'h0, 1'b0);

        // Randomized instructions.
        for (int i = 0; i < 150; i++) begin
            int          kind;
            int          ack_at;
            logic [1:0]  sz;
            logic [31:0] a;
            kind = $urandom_range(0, 2);
            sz   = 2'($urandom_range(0, 2));
            a    = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            ack_at = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 2, TO + 2)
                                                 : $urandom_range(0, 4);
            run_op(kind, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom, $urandom,
                   2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), ack_at, $urandom,
                   1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) bubble(1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of in_addr/bus_addr.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum bus-wait cycles before abort (range 2..255).
REQ-003 SHALL have ports:
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  instruction present in stage
- in_rd / in_wr  in  1 / 1  load / store request (never both)
- in_size  in  2  00 byte, 01 half, 10 word
- in_signed  in  1  sign-extend sub-word loads
- in_addr  in  ADDR_W  effective address (ALU result)
- in_wdata  in  32  store data, right-aligned
- in_alu / in_newpc  in  32 / 32  write-back candidates
- in_memtoreg  in  2  00 ALU, 01 load, 10 PC, 11 ALU
- in_dst  in  5  destination register
- stall  out  1  upstream holds inputs while high
- bus_req  out  1  bus cycle active
- bus_we  out  1  1 write, 0 read
- bus_addr  out  ADDR_W  word-aligned address (low 2 bits 0)
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_rdata  in  32  read data, valid with bus_ack
- bus_ack  in  1  bus cycle complete
- wb_valid / wb_dst / wb_data  out  1 / 5 / 32  registered write-back
- misalign_exc / timeout_exc  out  1 / 1  one-cycle exception pulses
- read_acc / write_acc  out  1 / 1  one-cycle pulses on acked read / write

Function
REQ-004 SHALL implement FSM IDLE, WAIT.
REQ-005 IDLE, in_valid, no rd/wr: SHALL register wb_valid=1, wb_dst=in_dst, wb_data=mux(in_memtoreg) next edge; stall=0.
REQ-006 IDLE, in_valid, rd|wr aligned: SHALL drive stall=1 combinationally, latch request, go WAIT.
REQ-007 Alignment: half SHALL need addr[0]=0, word addr[1:0]=00; misaligned SHALL issue no bus cycle, pulse misalign_exc, wb_valid=0, stall=0.
REQ-008 WAIT: bus_req=1, stall=1 while bus_ack=0; bus_addr/bus_we/bus_be/bus_wdata SHALL be stable.
REQ-009 WAIT with bus_ack: stall=0 that cycle; next edge SHALL return IDLE, pulse read_acc or write_acc, and for loads register wb_valid=1 with extracted data; stores give wb_valid=0.
REQ-010 bus_be: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-011 bus_wdata: byte {4{b}}, half {2{h}}, word unchanged.
REQ-012 Load data: selected lane of bus_rdata, zero- or sign-extended per in_signed; word unchanged.
REQ-013 Write-back mux with in_memtoreg=01 SHALL select extracted load data; 11 SHALL behave as 00.
REQ-014 Wait counter SHALL clear on WAIT entry and increment each unacked WAIT cycle; at TIMEOUT SHALL pulse timeout_exc, set wb_valid=0, return IDLE, stall=0.
REQ-015 bus_ack in IDLE SHALL be ignored.
REQ-016 wb_valid SHALL be a single-cycle pulse per retired instruction.
REQ-017 ack on the same cycle the counter reaches TIMEOUT SHALL count as completion, no exception.

Reset
REQ-018 reset low SHALL asynchronously force IDLE, counter 0, and all outputs 0 (stall, bus_req, bus_we, bus_addr, bus_be, bus_wdata, wb_*, exceptions, acc pulses).
REQ-019 reset mid-WAIT SHALL abandon the bus cycle with no write-back or pulse; first post-reset cycle SHALL be IDLE.

Structure
REQ-020 Shared package SHALL hold size codes, memtoreg codes, FSM state encoding, lane-select/extend function.
REQ-021 Lane steering (be, wdata replicate, load extract) SHALL be sub-module mem_lane_align; FSM, counter, wb register stay in top.

Verification
REQ-022 ALU op in_alu=0x12345678, memtoreg=00, dst=3 -> next cycle wb_valid=1, wb_data=0x12345678, wb_dst=3, stall never high.
REQ-023 lb signed addr 0x...03, ack after 2 wait cycles with bus_rdata=0x80FFFFFF -> bus_be=1000, stall 3 cycles, wb_data=0xFFFFFF80, read_acc one pulse.
REQ-024 sh addr 0x...02, in_wdata=0x0000BEEF -> bus_we=1, bus_be=1100, bus_wdata=0xBEEFBEEF, write_acc pulse, wb_valid=0.
REQ-025 lw addr 0x...02 -> misalign_exc pulse, bus_req stays 0, stall 0.
REQ-026 lw, TIMEOUT=16, no ack -> timeout_exc pulse after 16 WAIT cycles, stall then 0, wb_valid=0.
REQ-027 reset low during WAIT -> bus_req, stall drop asynchronously; no wb_valid or acc pulse afterward.
